tone_sequencer: RTL
===================

// Module: tone_sequencer
// PURPOSE
//   Parametrised multi-song square-wave note sequencer; successor to the single-song player.
//   Walks an external note table indexed by {song, index} and plays each note for its duration.
//   Supports rests, end-of-song markers, one-shot or loop playback, and a start/stop/done handshake.
//   Sits between game control (start/stop/song select) and the PWM audio pin.
// PARAMETERS
//   CLK_HZ     100_000_000  system clock frequency in Hz
//   DUR_DIV    8            duration units per second (1 unit = CLK_HZ/DUR_DIV cycles)
//   SONG_LEN   16           max notes per song; index width IDX_W = clog2(SONG_LEN)
//   NUM_SONGS  4            songs in table; select width SEL_W = clog2(NUM_SONGS), min 1
//   PERIOD_W   20           half-period field width (clock cycles)
//   DUR_W      5            duration field width (units)
//   ARTIC_CYC  1_000_000    silent gap between notes, cycles (used only with TONE_SEQ_ARTIC_EN)
// PORTS
//   clock        in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-high
//   start        in   1         1-cycle request; begins the selected song when idle
//   stop         in   1         abort playback; wins over start
//   song_sel     in   SEL_W     song number, sampled only on an accepted start
//   loop         in   1         1 = restart at index 0 after the end; sampled each song end
//   note_addr    out  SEL_W+IDX_W  {song, index} to the combinational note table
//   note_period  in   PERIOD_W  half-period in cycles; 0 = rest
//   note_dur     in   DUR_W     duration in units; 0 = end-of-song marker
//   audio_out    out  1         square-wave output
//   aud_sd       out  1         amplifier enable; constant 1
//   busy         out  1         high in every state except IDLE
//   done         out  1         1-cycle pulse when a non-looping song ends
// BEHAVIOUR
//   Reset: state IDLE, audio_out=0, busy=0, done=0, note_addr=0, all counters 0.
//   FSM: IDLE -> LOAD -> PLAY -> (GAP) -> LOAD ... -> DONE -> IDLE.
//   IDLE: accept start (and !stop): latch song_sel, index=0, go to LOAD next cycle.
//   LOAD (1 cycle): capture note_period and note_dur from the table at note_addr.
//     dur==0 -> song end. Else note_cyc = dur*(CLK_HZ/DUR_DIV), 32-bit product; go to PLAY.
//   PLAY: time_cnt counts 0..note_cyc-1. tone_cnt toggles audio_out when it reaches period-1,
//     then clears, so the wave period is 2*period cycles. period==0: audio_out held 0, no toggles.
//     Note end: audio_out=0. If index==SONG_LEN-1, song end; else index+1 and go to LOAD.
//   Song end: loop=1 -> index=0, LOAD (no done). loop=0 -> DONE.
//   DONE (1 cycle): done=1, then IDLE.
//   stop (any state): IDLE next cycle, audio_out=0, no done pulse, counters cleared.
//   start while busy is ignored; song_sel changes mid-song are ignored.
//   First note's first toggle occurs period cycles after PLAY entry.
// CONFIGURATION
//   TONE_SEQ_ARTIC_EN defined: after each non-final note, enter GAP for ARTIC_CYC cycles,
//     audio_out=0, then LOAD. stop still aborts from GAP.
//   Not defined: GAP state absent; notes play back-to-back (1 LOAD cycle between them).
// STRUCTURE
//   Package tone_seq_pkg: state encoding constants (IDLE/LOAD/PLAY/GAP/DONE),
//     REST_PERIOD=0 and END_DUR=0 markers.
//   Sub-module sq_wave_gen: tone_cnt plus toggle logic; inputs enable and period;
//     output wave, forced 0 when disabled or period==0.
//   Note table stays external; it is not part of this block.
// TESTING (bench: CLK_HZ=800, DUR_DIV=8 -> 1 unit=100 cycles, SONG_LEN=4)
//   Table song0={(5,2),(0,1),(3,1),(x,0)}, start, loop=0 -> 200 cyc toggling every 5,
//     100 cyc low, 100 cyc toggling every 3, then done pulse exactly once and busy=0.
//   Song1 full length, 4 notes with no end marker, loop=1 -> index wraps 3->0, no done,
//     busy stays 1.
//   stop asserted mid-note -> next cycle IDLE, audio_out=0, busy=0, no done;
//     a later start replays from index 0.
//   start and stop in the same cycle in IDLE -> remains IDLE; start while busy -> no effect.
//   reset asserted mid-PLAY -> immediate (asynchronous) reset values on all outputs.
//   TONE_SEQ_ARTIC_EN, ARTIC_CYC=20 -> 20 silent cycles between notes, none after the last note.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared definitions for the tone sequencer: FSM state encoding and table markers.
package tone_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // A zero half-period is a rest; a zero duration marks the end of a song.
    localparam int unsigned REST_PERIOD = 0;
    localparam int unsigned END_DUR     = 0;

endpackage

// File: rtl/tone_sequencer_sq_wave_gen.sv
// Square-wave generator: toggles wave every 'period' enabled cycles, held low when
// disabled or resting.
module sq_wave_gen
    import tone_seq_pkg::*;
#(
    parameter int unsigned PERIOD_W = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                wave
);

    logic [PERIOD_W-1:0] tone_cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tone_cnt_reg <= '0;
            wave         <= 1'b0;
        end else if (!enable || period == PERIOD_W'(REST_PERIOD)) begin
            tone_cnt_reg <= '0;
            wave         <= 1'b0;
        end else if (tone_cnt_reg == period - PERIOD_W'(1)) begin
            tone_cnt_reg <= '0;
            wave         <= ~wave;
        end else begin
            tone_cnt_reg <= tone_cnt_reg + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-song square-wave note sequencer walking an external {song, index} note table.
// Define TONE_SEQ_ARTIC_EN to insert an ARTIC_CYC-cycle silent gap between notes.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter  int unsigned CLK_HZ    = 100_000_000,
    parameter  int unsigned DUR_DIV   = 8,
    parameter  int unsigned SONG_LEN  = 16,
    parameter  int unsigned NUM_SONGS = 4,
    parameter  int unsigned PERIOD_W  = 20,
    parameter  int unsigned DUR_W     = 5,
    parameter  int unsigned ARTIC_CYC = 1_000_000,
    localparam int unsigned IDX_W     = $clog2(SONG_LEN),
    localparam int unsigned SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [SEL_W-1:0]       song_sel,
    input  logic                   loop,
    output logic [SEL_W+IDX_W-1:0] note_addr,
    input  logic [PERIOD_W-1:0]    note_period,
    input  logic [DUR_W-1:0]       note_dur,
    output logic                   audio_out,
    output logic                   aud_sd,
    output logic                   busy,
    output logic                   done
);

    localparam logic [31:0]      UNIT_CYC = 32'(CLK_HZ / DUR_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    state_t              state_reg;
    logic [SEL_W-1:0]    song_reg;
    logic [IDX_W-1:0]    index_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic [31:0]         note_cyc_reg;
    logic [31:0]         time_cnt_reg;
    logic                busy_reg;
    logic                done_reg;
`ifdef TONE_SEQ_ARTIC_EN
    logic [31:0]         gap_cnt_reg;
`endif

    logic note_end;
    logic tone_en;

    assign note_end  = (time_cnt_reg == note_cyc_reg - 32'd1);
    // Dropping enable on the last note cycle (or on stop) makes the wave low the
    // moment the sequencer leaves PLAY.
    assign tone_en   = (state_reg == PLAY) && !stop && !note_end;
    assign note_addr = {song_reg, index_reg};
    assign aud_sd    = 1'b1;
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            song_reg     <= '0;
            index_reg    <= '0;
            period_reg   <= '0;
            note_cyc_reg <= '0;
            time_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef TONE_SEQ_ARTIC_EN
            gap_cnt_reg  <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (stop) begin
                state_reg    <= IDLE;
                busy_reg     <= 1'b0;
                index_reg    <= '0;
                time_cnt_reg <= '0;
                note_cyc_reg <= '0;
`ifdef TONE_SEQ_ARTIC_EN
                gap_cnt_reg  <= '0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            song_reg  <= song_sel;
                            index_reg <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                    LOAD: begin
                        period_reg   <= note_period;
                        time_cnt_reg <= '0;
                        if (note_dur == DUR_W'(END_DUR)) begin
                            if (loop) begin
                                index_reg <= '0;
                            end else begin
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end
                        end else begin
                            note_cyc_reg <= 32'(note_dur) * UNIT_CYC;
                            state_reg    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (note_end) begin
                            time_cnt_reg <= '0;
                            if (index_reg == LAST_IDX) begin
                                if (loop) begin
                                    index_reg <= '0;
                                    state_reg <= LOAD;
                                end else begin
                                    done_reg  <= 1'b1;
                                    state_reg <= DONE;
                                end
                            end else begin
                                index_reg <= index_reg + IDX_W'(1);
`ifdef TONE_SEQ_ARTIC_EN
                                gap_cnt_reg <= '0;
                                state_reg   <= GAP;
`else
                                state_reg   <= LOAD;
`endif
                            end
                        end else begin
                            time_cnt_reg <= time_cnt_reg + 32'd1;
                        end
                    end
`ifdef TONE_SEQ_ARTIC_EN
                    GAP: begin
                        if (gap_cnt_reg == 32'(ARTIC_CYC - 1)) begin
                            gap_cnt_reg <= '0;
                            state_reg   <= LOAD;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 32'd1;
                        end
                    end
`endif
                    DONE: begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    sq_wave_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_wave (
        .clock  (clock),
        .reset  (reset),
        .enable (tone_en),
        .period (period_reg),
        .wave   (audio_out)
    );

endmodule
